stump_mem_if: RTL and testbench
===============================

Name: stump_mem_if

Overview:
- Parametrised memory-interface unit between the Stump core and memory or peripherals.
- Replaces the fixed single-cycle mem_ren/mem_wen access with a req/ack handshake. The core is stalled until the access completes, so slow or wait-stated memories are supported.
- Adds a bus timeout with sticky error reporting.
- Sits between the Stump top level's address/data_out/data_in/mem_ren/mem_wen and the system memory.

Parameters:
- DATA_W, 16, data bus width.
- ADDR_W, 16, address bus width.
- TIMEOUT, 15, maximum cycles mem_req may wait for mem_ack; 0 disables the timeout.
- TO_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  master reset, synchronous, active-high
- core_addr  input  ADDR_W  access address from core
- core_wdata  input  DATA_W  write data from core
- core_ren  input  1  core read request
- core_wen  input  1  core write request
- core_rdata  output  DATA_W  read data to core
- core_stall  output  1  core must hold state and request this cycle
- mem_addr  output  ADDR_W  registered address to memory
- mem_wdata  output  DATA_W  registered write data
- mem_req  output  1  access request to memory
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high
- mem_rdata  input  DATA_W  read data from memory; valid when mem_ack is high
- mem_ack  input  1  access complete; single-cycle pulse
- bus_err  output  1  sticky timeout flag
- clr_err  input  1  clears bus_err

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; all registers update on the rising edge of clk.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rdata=0, bus_err=0, timeout counter=0. core_stall=0 while rst is high.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If core_ren|core_wen is high, core_stall=1 combinationally in the same cycle.
  - At the edge: latch core_addr into mem_addr, latch core_wdata into mem_wdata, set mem_we=core_wen, set mem_req=1, clear the counter, go to BUSY.
  - If core_ren and core_wen are both high, the access is a write.
- BUSY:
  - core_stall=1 and mem_req=1; the counter increments each cycle.
  - If mem_ack is high, at the edge: core_rdata<=mem_rdata (reads only; writes leave core_rdata unchanged), mem_req<=0, go to RESP.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no ack, at the edge: mem_req<=0, bus_err<=1, core_rdata<={DATA_W{1'b1}} for reads, go to RESP.
  - mem_ack arriving on the expiry cycle takes priority over the timeout.
- RESP:
  - Lasts one cycle; core_stall=0 and core_rdata is valid, so the core completes the access at this edge.
  - core_ren/core_wen are ignored in this cycle because they belong to the completed access. Go to IDLE.
- Latency: minimum 3 cycles from request to stall release (mem_ack in the first BUSY cycle). Back-to-back accesses cost 3 cycles each plus memory wait states.
- mem_ack while not in BUSY is ignored.
- mem_addr, mem_wdata and mem_we are stable for the whole time mem_req is high.
- bus_err:
  - Set only by a timeout; cleared by clr_err or rst.
  - If clr_err and a timeout occur in the same cycle, the set wins.
- Reset mid-operation: at the reset edge mem_req drops and state goes to IDLE. A late mem_ack after that is ignored.
- Counter width is TO_W; it saturates and never wraps.

Optional Feature:
- Macro: STUMP_MEM_IF_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0]; both reset to 0.
  - Each increments on the edge leaving BUSY by mem_ack, for reads or writes respectively, and wraps 0xFFFF→0x0000.
  - Timed-out accesses are not counted.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Read, ack in the first BUSY cycle, mem_rdata=0x1234, core_addr=0x0040:
  - mem_addr=0x0040, mem_we=0, mem_req high for 1 cycle.
  - core_stall high for 2 cycles; core_rdata=0x1234 in RESP.
- Write core_addr=0x00FF, core_wdata=0xBEEF, ack delayed 4 cycles:
  - mem_wdata=0xBEEF stable while mem_req is high for 5 cycles.
  - core_stall released in RESP; core_rdata unchanged.
- Read with no ack, TIMEOUT=15:
  - mem_req high for exactly 15 cycles.
  - bus_err=1; core_rdata=0xFFFF.
  - bus_err stays 1 until a clr_err pulse clears it.
- core_ren=core_wen=1 → mem_we=1 (treated as a write). Spurious mem_ack in IDLE → no state change.
- rst asserted during the 2nd BUSY cycle → next edge: mem_req=0, state IDLE. A mem_ack one cycle later is ignored; core_stall=0.
- STUMP_MEM_IF_STATS_EN defined, 3 reads, 2 writes, 1 timeout → rd_count=3, wr_count=2.

Source files
------------

// File: rtl/stump_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : stump_mem_if
//  Purpose  : Memory interface between the Stump core and system memory or
//             peripherals. Converts the core's single-cycle read/write strobes
//             into a req/ack handshake, stalls the core while the access is
//             outstanding, and reports a sticky bus error on timeout.
//  Options  : STUMP_MEM_IF_STATS_EN adds rd_count/wr_count access counters.
//  Revision : 1.0 - initial release
// ============================================================================
module stump_mem_if #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15,   // 0 disables the timeout
   parameter int TO_W    = 8     // TIMEOUT must be below 2**TO_W
) (
   input  logic              clk,
   input  logic              rst,
   // core side
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   input  logic              core_ren,
   input  logic              core_wen,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   // memory side
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_req,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   // error reporting
   output logic              bus_err,
`ifdef STUMP_MEM_IF_STATS_EN
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count,
`endif
   input  logic              clr_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam bit              c_TO_EN   = (TIMEOUT != 0);
   // Count value seen in the last BUSY cycle before the access is abandoned.
   localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] c_CNT_MAX = {TO_W{1'b1}};

   state_t            r_state;
   state_t            w_next_state;
   logic              w_stall;
   logic              w_launch;
   logic              w_ack_done;
   logic              w_timeout;

   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [DATA_W-1:0] r_core_rdata;
   logic              r_bus_err;
   logic [TO_W-1:0]   r_cnt;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state, core stall and the launch/complete/abandon strobes.
   always_comb begin
      w_next_state = r_state;
      w_stall      = 1'b0;
      w_launch     = 1'b0;
      w_ack_done   = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (core_ren || core_wen) begin
               w_stall      = 1'b1;
               w_launch     = 1'b1;
               w_next_state = ST_BUSY;
            end
         end
         ST_BUSY: begin
            w_stall = 1'b1;
            // An ack on the expiry cycle still completes the access normally.
            if (mem_ack) begin
               w_ack_done   = 1'b1;
               w_next_state = ST_RESP;
            end else if (c_TO_EN && (r_cnt == c_TO_LAST)) begin
               w_timeout    = 1'b1;
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            // Core strobes here belong to the access just completed.
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Request, address, write data and direction captured at launch and held
   // unchanged for as long as the request is outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else if (w_launch) begin
         r_mem_req   <= 1'b1;
         r_mem_we    <= core_wen;   // read+write together is a write
         r_mem_addr  <= core_addr;
         r_mem_wdata <= core_wdata;
      end else if (w_ack_done || w_timeout) begin
         r_mem_req   <= 1'b0;
      end
   end

   // Wait-state counter: cleared at launch, saturating while BUSY.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_launch) begin
         r_cnt <= '0;
      end else if ((r_state == ST_BUSY) && (r_cnt != c_CNT_MAX)) begin
         r_cnt <= r_cnt + TO_W'(1);
      end
   end

   // Read data returned to the core; all ones marks an abandoned read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_core_rdata <= '0;
      end else if (w_ack_done && !r_mem_we) begin
         r_core_rdata <= mem_rdata;
      end else if (w_timeout && !r_mem_we) begin
         r_core_rdata <= {DATA_W{1'b1}};
      end
   end

   // Sticky bus error; a timeout beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bus_err <= 1'b0;
      end else if (w_timeout) begin
         r_bus_err <= 1'b1;
      end else if (clr_err) begin
         r_bus_err <= 1'b0;
      end
   end

`ifdef STUMP_MEM_IF_STATS_EN
   logic [15:0] r_rd_count;
   logic [15:0] r_wr_count;

   // Completed-access counters; abandoned accesses are not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_count <= '0;
         r_wr_count <= '0;
      end else if (w_ack_done) begin
         if (r_mem_we) begin
            r_wr_count <= r_wr_count + 16'd1;
         end else begin
            r_rd_count <= r_rd_count + 16'd1;
         end
      end
   end

   assign rd_count = r_rd_count;
   assign wr_count = r_wr_count;
`endif

   assign core_stall = w_stall & ~rst;
   assign core_rdata = r_core_rdata;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign bus_err    = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_stump_mem_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stump_mem_if
//  Purpose  : Self-checking bench for stump_mem_if. Expected outputs come from
//             a transaction-level model: each access is described by its kind,
//             address, data and ack delay, from which the request length,
//             stall length, returned data and error flag are derived.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stump_mem_if;

   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 16;
   localparam int TIMEOUT = 15;
   localparam int TO_W    = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_ren;
   logic              core_wen;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              bus_err;
   logic              clr_err;
`ifdef STUMP_MEM_IF_STATS_EN
   logic [15:0]       rd_count;
   logic [15:0]       wr_count;
`endif

   stump_mem_if #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .TIMEOUT(TIMEOUT),
      .TO_W   (TO_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .core_addr (core_addr),
      .core_wdata(core_wdata),
      .core_ren  (core_ren),
      .core_wen  (core_wen),
      .core_rdata(core_rdata),
      .core_stall(core_stall),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .bus_err   (bus_err),
`ifdef STUMP_MEM_IF_STATS_EN
      .rd_count  (rd_count),
      .wr_count  (wr_count),
`endif
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   // Model state: what every output must be in the current cycle.
   logic              exp_stall;
   logic              exp_req;
   logic              exp_we;
   logic              exp_err;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_wdata;
   logic [DATA_W-1:0] exp_rdata;
   int                m_rd = 0;
   int                m_wr = 0;
   bit                chk_en = 1'b0;

   int n_checks    = 0;
   int n_fail      = 0;
   int req_total   = 0;
   int stall_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic compare_outputs();
      check("core_stall", {31'd0, core_stall}, {31'd0, exp_stall});
      check("mem_req",    {31'd0, mem_req},    {31'd0, exp_req});
      check("mem_we",     {31'd0, mem_we},     {31'd0, exp_we});
      check("mem_addr",   {16'd0, mem_addr},   {16'd0, exp_addr});
      check("mem_wdata",  {16'd0, mem_wdata},  {16'd0, exp_wdata});
      check("core_rdata", {16'd0, core_rdata}, {16'd0, exp_rdata});
      check("bus_err",    {31'd0, bus_err},    {31'd0, exp_err});
   endtask

   // One clock cycle: compare on the falling edge, then advance the error
   // flag model across the rising edge (a timeout beats a clear).
   task automatic step(input bit timeout_now);
      @(negedge clk);
      if (mem_req === 1'b1)    req_total++;
      if (core_stall === 1'b1) stall_total++;
      if (chk_en) compare_outputs();
      @(posedge clk);
      if (timeout_now)  exp_err = 1'b1;
      else if (clr_err) exp_err = 1'b0;
      #1;
   endtask

   task automatic reset_model();
      exp_req   = 1'b0;
      exp_we    = 1'b0;
      exp_err   = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      exp_rdata = '0;
      m_rd      = 0;
      m_wr      = 0;
   endtask

   task automatic idle(input int n, input bit noise);
      for (int i = 0; i < n; i++) begin
         core_ren   = 1'b0;
         core_wen   = 1'b0;
         core_addr  = ADDR_W'($urandom);
         core_wdata = DATA_W'($urandom);
         mem_rdata  = DATA_W'($urandom);
         mem_ack    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         clr_err    = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
         exp_stall  = 1'b0;
         exp_req    = 1'b0;
         step(1'b0);
      end
   endtask

   // One complete access. delay = number of BUSY cycles before the ack;
   // delay >= TIMEOUT means memory never answers.
   task automatic access(input bit ren, input bit wen,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input int delay, input logic [DATA_W-1:0] rd_val,
                         input bit noise);
      bit acked;
      int nbusy;
      acked = (delay < TIMEOUT);
      nbusy = acked ? delay + 1 : TIMEOUT;
      // request cycle
      core_ren   = ren;
      core_wen   = wen;
      core_addr  = addr;
      core_wdata = wdata;
      mem_ack    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata  = DATA_W'($urandom);
      clr_err    = noise ? ($urandom_range(0, 5) == 0) : 1'b0;
      exp_stall  = 1'b1;
      exp_req    = 1'b0;
      step(1'b0);
      // waiting for memory
      exp_req   = 1'b1;
      exp_addr  = addr;
      exp_wdata = wdata;
      exp_we    = wen;
      for (int i = 1; i <= nbusy; i++) begin
         mem_ack   = acked && (i == nbusy);
         mem_rdata = mem_ack ? rd_val : DATA_W'($urandom);
         clr_err   = noise ? ($urandom_range(0, 5) == 0) : 1'b0;
         step(!acked && (i == nbusy));
      end
      // response cycle: core strobes still high but must be ignored
      exp_req   = 1'b0;
      exp_stall = 1'b0;
      if (!wen) exp_rdata = acked ? rd_val : {DATA_W{1'b1}};
      if (acked) begin
         if (wen) m_wr++;
         else     m_rd++;
      end
      mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = DATA_W'($urandom);
      clr_err   = noise ? ($urandom_range(0, 5) == 0) : 1'b0;
      step(1'b0);
      core_ren = 1'b0;
      core_wen = 1'b0;
      mem_ack  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r0;
      int s0;
      int kind;
      int sel;
      int dly;
      // reset, with a request pending to show the stall is masked
      rst        = 1'b1;
      core_ren   = 1'b1;
      core_wen   = 1'b0;
      core_addr  = 16'h0011;
      core_wdata = 16'h0022;
      mem_rdata  = '0;
      mem_ack    = 1'b0;
      clr_err    = 1'b0;
      reset_model();
      exp_stall  = 1'b0;
      step(1'b0);
      chk_en = 1'b1;
      step(1'b0);
      step(1'b0);
      rst      = 1'b0;
      core_ren = 1'b0;
      idle(2, 1'b0);

      // read, ack in the first BUSY cycle
      r0 = req_total; s0 = stall_total;
      access(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'h1234, 1'b0);
      check("t1_req_cycles",   req_total - r0,   1);
      check("t1_stall_cycles", stall_total - s0, 2);
      check("t1_rdata",        {16'd0, core_rdata}, 32'h1234);
      check("t1_addr",         {16'd0, mem_addr},   32'h0040);
      check("t1_we",           {31'd0, mem_we},     0);
      idle(1, 1'b0);

      // write, ack after four wait states
      r0 = req_total; s0 = stall_total;
      access(1'b0, 1'b1, 16'h00FF, 16'hBEEF, 4, 16'h0BAD, 1'b0);
      check("t2_req_cycles",   req_total - r0,   5);
      check("t2_stall_cycles", stall_total - s0, 6);
      check("t2_wdata",        {16'd0, mem_wdata},  32'hBEEF);
      check("t2_rdata_kept",   {16'd0, core_rdata}, 32'h1234);
      idle(1, 1'b0);

      // read that never gets an ack
      r0 = req_total;
      access(1'b1, 1'b0, 16'h0100, 16'h0000, 99, 16'h0000, 1'b0);
      check("t3_req_cycles", req_total - r0, 15);
      check("t3_rdata",      {16'd0, core_rdata}, 32'hFFFF);
      check("t3_err",        {31'd0, bus_err}, 1);
      idle(4, 1'b0);
      check("t3_err_sticky", {31'd0, bus_err}, 1);
      clr_err = 1'b1;
      step(1'b0);
      clr_err = 1'b0;
      idle(1, 1'b0);
      check("t3_err_cleared", {31'd0, bus_err}, 0);

      // read and write together is a write; stray ack while idle
      access(1'b1, 1'b1, 16'h2222, 16'h5555, 1, 16'h7777, 1'b0);
      check("t4_we", {31'd0, mem_we}, 1);
      core_ren  = 1'b0;
      core_wen  = 1'b0;
      mem_ack   = 1'b1;
      exp_stall = 1'b0;
      step(1'b0);
      mem_ack = 1'b0;
      step(1'b0);
      check("t4_req_idle",   {31'd0, mem_req},    0);
      check("t4_stall_idle", {31'd0, core_stall}, 0);

      // reset during the second BUSY cycle, late ack afterwards
      core_ren   = 1'b1;
      core_addr  = 16'h3333;
      core_wdata = 16'h4444;
      exp_stall  = 1'b1;
      step(1'b0);
      exp_req   = 1'b1;
      exp_addr  = 16'h3333;
      exp_wdata = 16'h4444;
      exp_we    = 1'b0;
      step(1'b0);
      rst       = 1'b1;
      exp_stall = 1'b0;
      step(1'b0);
      reset_model();
      rst      = 1'b0;
      core_ren = 1'b0;
      mem_ack  = 1'b1;
      step(1'b0);
      check("t5_req_after_rst",   {31'd0, mem_req},    0);
      check("t5_stall_after_rst", {31'd0, core_stall}, 0);
      mem_ack = 1'b0;
      idle(2, 1'b0);

      // 3 reads, 2 writes, 1 abandoned read
      access(1'b1, 1'b0, 16'h0001, 16'h0000, 0,  16'hA001, 1'b0);
      access(1'b0, 1'b1, 16'h0002, 16'hB002, 2,  16'h0000, 1'b0);
      access(1'b1, 1'b0, 16'h0003, 16'h0000, 14, 16'hA003, 1'b0);
      check("t6_ack_on_expiry", {31'd0, bus_err}, 0);
      check("t6_expiry_rdata",  {16'd0, core_rdata}, 32'hA003);
      access(1'b1, 1'b0, 16'h0004, 16'h0000, 40, 16'h0000, 1'b0);
      access(1'b0, 1'b1, 16'h0005, 16'hB005, 1,  16'h0000, 1'b0);
      access(1'b1, 1'b0, 16'h0006, 16'h0000, 3,  16'hA006, 1'b0);
`ifdef STUMP_MEM_IF_STATS_EN
      check("t6_rd_count", {16'd0, rd_count}, 3);
      check("t6_wr_count", {16'd0, wr_count}, 2);
`endif
      idle(1, 1'b0);

      // randomized traffic with noise on ack and clear
      for (int t = 0; t < 150; t++) begin
         kind = int'($urandom_range(0, 2));
         sel  = int'($urandom_range(0, 9));
         if (sel <= 5)      dly = int'($urandom_range(0, 3));
         else if (sel <= 7) dly = TIMEOUT - 1 - int'($urandom_range(0, 1));
         else if (sel == 8) dly = TIMEOUT + int'($urandom_range(0, 5));
         else               dly = int'($urandom_range(4, 12));
         access(kind != 1, kind != 0, ADDR_W'($urandom), DATA_W'($urandom),
                dly, DATA_W'($urandom), 1'b1);
         idle(int'($urandom_range(0, 2)), 1'b1);
      end
      idle(2, 1'b1);
`ifdef STUMP_MEM_IF_STATS_EN
      check("rand_rd_count", {16'd0, rd_count}, 32'(m_rd[15:0]));
      check("rand_wr_count", {16'd0, wr_count}, 32'(m_wr[15:0]));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
